// File: rtl/counter_timer_multi.sv
// counter_timer_multi
//   Bank of CHANNELS independent up/down timers. Each channel has four
//   registers that share one flat register port:
//     sel=0 cfg    [0] enable [1] oneshot [2] up [3] irq_en [4] chain
//                  [15:8] prescale (only with COUNTER_TIMER_PRESCALE_EN)
//     sel=1 value  running count
//     sel=2 data   reload value (down) / limit (up)
//     sel=3 status [0] terminal seen; write 1 to clear
//   Optional feature macro: COUNTER_TIMER_PRESCALE_EN adds an 8-bit
//   per-channel prescaler. When it is undefined, every cycle is a
//   prescale tick and cfg[15:8] reads 0.
//
// Ports
//   clkin     sole clock, rising edge
//   resetn    asynchronous active-low reset
//   reg_addr  {channel index, sel[1:0]}
//   reg_we    write strobe, one write per asserted cycle
//   reg_di    write data
//   reg_do    read data, combinational from reg_addr (0 for absent channels)
//   irq       per-channel level interrupt = status[0] & irq_en
module counter_timer_multi #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
) (
    input  logic                        clkin,
    input  logic                        resetn,
    input  logic [$clog2(CHANNELS)+1:0] reg_addr,
    input  logic                        reg_we,
    input  logic [WIDTH-1:0]            reg_di,
    output logic [WIDTH-1:0]            reg_do,
    output logic [CHANNELS-1:0]         irq
);

    logic [1:0]       sel;
    logic [31:0]      ch_idx;
    logic [WIDTH-1:0] ch_rd [CHANNELS];

    assign sel    = reg_addr[1:0];
    assign ch_idx = 32'(reg_addr >> 2);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic             en, oneshot, up, irq_en, chain, status;
        logic [WIDTH-1:0] value, data, value_nxt, rd;
        logic [15:0]      cfg_rd;
        logic             hit, wr_cfg, wr_val, wr_dat, wr_sts;
        logic             link_ok, ptick, at_limit, tick, term;

        assign hit    = reg_we && (ch_idx == 32'(n));
        assign wr_cfg = hit && (sel == 2'd0);
        assign wr_val = hit && (sel == 2'd1);
        assign wr_dat = hit && (sel == 2'd2);
        assign wr_sts = hit && (sel == 2'd3);

        // A chained channel advances only on the cycle its lower
        // neighbour hits its terminal event; channel 0 has no neighbour.
        if (n == 0) begin : g_head
            assign link_ok = 1'b1;
        end else begin : g_link
            assign link_ok = !chain || g_ch[n-1].term;
        end

`ifdef COUNTER_TIMER_PRESCALE_EN
        logic [7:0] psc, pcnt, di_psc;

        assign di_psc = 8'(reg_di >> 8);
        assign ptick  = (pcnt == psc);
        assign cfg_rd = {psc, 3'b000, chain, irq_en, up, oneshot, en};

        // Any cfg write restarts the prescale period from zero.
        always_ff @(posedge clkin or negedge resetn) begin
            if (!resetn) begin
                psc  <= '0;
                pcnt <= '0;
            end else begin
                if (wr_cfg)
                    psc <= di_psc;
                if (wr_cfg || ptick)
                    pcnt <= '0;
                else
                    pcnt <= pcnt + 8'd1;
            end
        end
`else
        assign ptick  = 1'b1;
        assign cfg_rd = {8'h00, 3'b000, chain, irq_en, up, oneshot, en};
`endif

        assign tick = en && ptick && link_ok;

        // In up mode a value written above the limit terminates at once
        // rather than counting through all-ones and wrapping.
        assign at_limit = up ? (value >= data) : (value == '0);
        assign term     = tick && at_limit;

        always_comb begin
            value_nxt = value;
            if (tick) begin
                if (!at_limit)
                    value_nxt = up ? value + WIDTH'(1) : value - WIDTH'(1);
                else if (!oneshot)
                    value_nxt = up ? '0 : data;
            end
        end

        // Register writes override the tick update of the same register;
        // the terminal event still reaches status, and a set beats a clear.
        always_ff @(posedge clkin or negedge resetn) begin
            if (!resetn) begin
                en      <= 1'b0;
                oneshot <= 1'b0;
                up      <= 1'b0;
                irq_en  <= 1'b0;
                chain   <= 1'b0;
                status  <= 1'b0;
                value   <= '0;
                data    <= '0;
            end else begin
                if (wr_cfg) begin
                    en      <= reg_di[0];
                    oneshot <= reg_di[1];
                    up      <= reg_di[2];
                    irq_en  <= reg_di[3];
                    chain   <= reg_di[4];
                end else if (term && oneshot) begin
                    en <= 1'b0;
                end
                value <= wr_val ? reg_di : value_nxt;
                if (wr_dat)
                    data <= reg_di;
                status <= term || (status && !(wr_sts && reg_di[0]));
            end
        end

        always_comb begin
            case (sel)
                2'd0:    rd = WIDTH'(cfg_rd);
                2'd1:    rd = value;
                2'd2:    rd = data;
                default: rd = WIDTH'(status);
            endcase
        end

        assign ch_rd[n] = rd;
        assign irq[n]   = status && irq_en;
    end

    // Channel indices with no channel behind them read as zero.
    always_comb begin
        reg_do = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (ch_idx == 32'(i))
                reg_do = ch_rd[i];
    end

endmodule

// File: tb/tb_counter_timer_multi.sv
module tb_counter_timer_multi;

    localparam int W   = 16;
    localparam int NCH = 3;

    logic          clkin;
    logic          resetn;
    logic [3:0]    reg_addr;
    logic          reg_we;
    logic [W-1:0]  reg_di;
    logic [W-1:0]  reg_do;
    logic [NCH-1:0] irq;

    int n_chk  = 0;
    int n_fail = 0;

    counter_timer_multi #(.WIDTH(W), .CHANNELS(NCH)) dut (
        .clkin   (clkin),
        .resetn  (resetn),
        .reg_addr(reg_addr),
        .reg_we  (reg_we),
        .reg_di  (reg_di),
        .reg_do  (reg_do),
        .irq     (irq)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int m_en[NCH], m_os[NCH], m_up[NCH], m_ie[NCH], m_ch[NCH], m_st[NCH];
    int m_v[NCH], m_d[NCH];

    task automatic m_clear();
        for (int n = 0; n < NCH; n++) begin
            m_en[n] = 0; m_os[n] = 0; m_up[n] = 0; m_ie[n] = 0; m_ch[n] = 0;
            m_st[n] = 0; m_v[n] = 0; m_d[n] = 0;
        end
    endtask

    function automatic int m_read(int addr);
        int idx = addr >> 2;
        int s   = addr & 3;
        if (idx >= NCH) return 0;
        case (s)
            0:       return m_en[idx] | (m_os[idx] << 1) | (m_up[idx] << 2) |
                            (m_ie[idx] << 3) | (m_ch[idx] << 4);
            1:       return m_v[idx];
            2:       return m_d[idx];
            default: return m_st[idx];
        endcase
    endfunction

    function automatic int m_irq();
        int r = 0;
        for (int n = 0; n < NCH; n++)
            if (m_st[n] != 0 && m_ie[n] != 0) r = r | (1 << n);
        return r;
    endfunction

    task automatic m_step(input int we, input int addr, input int di);
        int prev_term = 0;
        int idx = addr >> 2;
        int s   = addr & 3;
        for (int n = 0; n < NCH; n++) begin
            int tick, lim, term;
            tick = (m_en[n] != 0) && (n == 0 || m_ch[n] == 0 || prev_term != 0);
            lim  = (m_up[n] != 0) ? (m_v[n] >= m_d[n]) : (m_v[n] == 0);
            term = tick && lim;
            if (tick) begin
                if (!lim)
                    m_v[n] = (m_up[n] != 0) ? m_v[n] + 1 : m_v[n] - 1;
                else if (m_os[n] == 0)
                    m_v[n] = (m_up[n] != 0) ? 0 : m_d[n];
                else
                    m_en[n] = 0;
            end
            if (term)
                m_st[n] = 1;
            else if (we != 0 && idx == n && s == 3 && (di & 1) != 0)
                m_st[n] = 0;
            if (we != 0 && idx == n) begin
                case (s)
                    0: begin
                        m_en[n] = di & 1;        m_os[n] = (di >> 1) & 1;
                        m_up[n] = (di >> 2) & 1; m_ie[n] = (di >> 3) & 1;
                        m_ch[n] = (di >> 4) & 1;
                    end
                    1: m_v[n] = di;
                    2: m_d[n] = di;
                    default: ;
                endcase
            end
            prev_term = term;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [3:0] a, input logic [15:0] d);
        reg_we   = w;
        reg_addr = a;
        reg_di   = d;
        #1;
    endtask

    task automatic tick_clk();
        @(posedge clkin);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        drive(1'b1, a, d);
        tick_clk();
    endtask

    task automatic do_reset();
        reg_we = 1'b0;
        resetn = 1'b0;
        tick_clk();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] di;
        logic [15:0] exp_do;
        logic [2:0]  exp_irq;
    } vec_t;

    vec_t tbl [20];

    initial begin
        reg_we = 1'b0; reg_addr = '0; reg_di = '0; resetn = 1'b0;

        // Oneshot down count on ch0, then status clear and absent channel 3.
        tbl[0]  = '{1'b0, 4'd0,  16'h0000, 16'h0000, 3'd0};
        tbl[1]  = '{1'b1, 4'd2,  16'h0000, 16'h0000, 3'd0};
        tbl[2]  = '{1'b1, 4'd1,  16'h0005, 16'h0000, 3'd0};
        tbl[3]  = '{1'b1, 4'd0,  16'h000B, 16'h0000, 3'd0};
        tbl[4]  = '{1'b0, 4'd1,  16'h0000, 16'h0005, 3'd0};
        tbl[5]  = '{1'b0, 4'd1,  16'h0000, 16'h0004, 3'd0};
        tbl[6]  = '{1'b0, 4'd1,  16'h0000, 16'h0003, 3'd0};
        tbl[7]  = '{1'b0, 4'd1,  16'h0000, 16'h0002, 3'd0};
        tbl[8]  = '{1'b0, 4'd1,  16'h0000, 16'h0001, 3'd0};
        tbl[9]  = '{1'b0, 4'd1,  16'h0000, 16'h0000, 3'd0};
        tbl[10] = '{1'b0, 4'd1,  16'h0000, 16'h0000, 3'd1};
        tbl[11] = '{1'b0, 4'd0,  16'h0000, 16'h000A, 3'd1};
        tbl[12] = '{1'b0, 4'd3,  16'h0000, 16'h0001, 3'd1};
        tbl[13] = '{1'b0, 4'd1,  16'h0000, 16'h0000, 3'd1};
        tbl[14] = '{1'b1, 4'd3,  16'h0001, 16'h0001, 3'd1};
        tbl[15] = '{1'b0, 4'd3,  16'h0000, 16'h0000, 3'd0};
        tbl[16] = '{1'b0, 4'd12, 16'h0000, 16'h0000, 3'd0};
        tbl[17] = '{1'b1, 4'd13, 16'h0055, 16'h0000, 3'd0};
        tbl[18] = '{1'b0, 4'd13, 16'h0000, 16'h0000, 3'd0};
        tbl[19] = '{1'b0, 4'd5,  16'h0000, 16'h0000, 3'd0};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].di);
            chk($sformatf("tbl%0d_do", i), reg_do, tbl[i].exp_do);
            chk($sformatf("tbl%0d_irq", i), 16'(irq), 16'(tbl[i].exp_irq));
            tick_clk();
        end

        // Continuous up count 0..3 with status set and clear.
        do_reset();
        wr(4'd2, 16'd3);
        wr(4'd1, 16'd0);
        wr(4'd0, 16'h0005);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 4'd1, 16'h0);
            chk($sformatf("up_val%0d", k), reg_do, 16'(k % 4));
            tick_clk();
        end
        drive(1'b1, 4'd3, 16'h1);
        chk("up_status_set", reg_do, 16'h1);
        tick_clk();
        drive(1'b0, 4'd3, 16'h0);
        chk("up_status_clr", reg_do, 16'h0);
        tick_clk();
        drive(1'b0, 4'd1, 16'h0);
        chk("up_after_clr", reg_do, 16'h2);
        tick_clk();

        // Chain: ch1 steps once per ch0 period of 3 cycles.
        do_reset();
        wr(4'd2, 16'd2);
        wr(4'd1, 16'd2);
        wr(4'd5, 16'd3);
        wr(4'd4, 16'h0011);
        wr(4'd0, 16'h0001);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 4'd5, 16'h0);
            chk($sformatf("chain_val%0d", c), reg_do, 16'(3 - c / 3));
            tick_clk();
        end
        drive(1'b0, 4'd7, 16'h0);
        chk("chain_term", reg_do, 16'h1);
        tick_clk();

        // Write precedence over tick, and status set beating clear.
        do_reset();
        wr(4'd1, 16'd10);
        wr(4'd0, 16'h0001);
        drive(1'b1, 4'd1, 16'h0100);
        chk("prec_before", reg_do, 16'd10);
        tick_clk();
        drive(1'b0, 4'd1, 16'h0);
        chk("prec_written", reg_do, 16'h0100);
        tick_clk();
        drive(1'b1, 4'd1, 16'h0001);
        chk("prec_dec", reg_do, 16'h00FF);
        tick_clk();
        drive(1'b0, 4'd1, 16'h0);
        chk("prec_one", reg_do, 16'h0001);
        tick_clk();
        drive(1'b1, 4'd3, 16'h0001);
        chk("sts_before", reg_do, 16'h0);
        tick_clk();
        drive(1'b0, 4'd3, 16'h0);
        chk("sts_set_wins", reg_do, 16'h1);
        tick_clk();

        // Asynchronous reset mid-count.
        do_reset();
        wr(4'd4, 16'h0009);
        wr(4'd1, 16'h0030);
        wr(4'd0, 16'h0009);
        for (int k = 0; k < 23; k++) tick_clk();
        drive(1'b0, 4'd1, 16'h0);
        chk("rst_pre_val", reg_do, 16'h0019);
        chk("rst_pre_irq", 16'(irq), 16'h2);
        resetn = 1'b0;
        #1;
        chk("rst_val", reg_do, 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        drive(1'b0, 4'd0, 16'h0);
        chk("rst_cfg", reg_do, 16'h0);
        drive(1'b0, 4'd7, 16'h0);
        chk("rst_sts1", reg_do, 16'h0);
        tick_clk();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'd1, 16'h0);
            chk($sformatf("post_rst_val%0d", k), reg_do, 16'h0);
            chk($sformatf("post_rst_irq%0d", k), 16'(irq), 16'h0);
            tick_clk();
        end

`ifdef COUNTER_TIMER_PRESCALE_EN
        // Prescale 3: value changes every 4 cycles, terminal every 8.
        do_reset();
        wr(4'd2, 16'd1);
        wr(4'd1, 16'd1);
        wr(4'd0, 16'h0301);
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 4'd1, 16'h0);
            chk($sformatf("psc_val%0d", c), reg_do, 16'(((c / 4) % 2 == 0) ? 1 : 0));
            tick_clk();
        end
        drive(1'b0, 4'd3, 16'h0);
        chk("psc_status", reg_do, 16'h1);
        drive(1'b0, 4'd0, 16'h0);
        chk("psc_cfg", reg_do, 16'h0301);
        tick_clk();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        m_clear();
        for (int c = 0; c < 600; c++) begin
            int we, addr, di, s;
            we   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            addr = int'($urandom_range(0, 15));
            s    = addr & 3;
            case (s)
                0:       di = int'($urandom_range(0, 31));
                1, 2:    di = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                                          : int'($urandom_range(0, 12));
                default: di = int'($urandom_range(0, 1));
            endcase
            drive(1'(we), 4'(addr), 16'(di));
            chk($sformatf("rnd%0d_do", c), reg_do, 16'(m_read(addr)));
            chk($sformatf("rnd%0d_irq", c), 16'(irq), 16'(m_irq()));
            m_step(we, addr, di);
            tick_clk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
